// File: rtl/manch_pkg.sv
// Shared definitions for the Manchester transmitter: state encodings,
// baud-period derivation and the stop-bit pattern.
package manch_pkg;

  typedef enum logic [2:0] {
    RESET_S = 3'b000,
    IDLE_S  = 3'b001,
    SEND_S  = 3'b010,
    GAP_S   = 3'b100
  } state_e;

  // Stop bits are all zero except the final one, which leaves the line high.
  localparam logic STOP_LAST = 1'b1;

  function automatic int unsigned full_baud(input int unsigned clk_freq,
                                            input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned half_baud(input int unsigned clk_freq,
                                            input int unsigned baud);
    return full_baud(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/manch_halfbit_timer.sv
// Half-bit period timer: counts 0..HALFBAUD-1 and flags the wrap cycle.
module manch_halfbit_timer #(
  parameter int unsigned HALFBAUD = 81
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic wrap_o
);

  localparam int unsigned CW = (HALFBAUD > 1) ? $clog2(HALFBAUD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == CW'(HALFBAUD - 1)) && !clear_i;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || wrap_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/manch_encoder.sv
// Manchester serial transmitter: start bit, MSB-first data, stop bits,
// with an idle-high guard gap ahead of every frame.
//
//   state   | meaning
//   RESET_S | one cycle after reset release, clears counters
//   GAP_S   | line held high for GAP_HALFBITS half-bit periods
//   IDLE_S  | line high, ready for a byte
//   SEND_S  | shifting the frame out, two half-bits per bit
module manch_encoder
  import manch_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 2,
  parameter int unsigned BAUDRATE     = 115200,
  parameter int unsigned CLK_FREQ     = 18_750_000,
  parameter int unsigned GAP_HALFBITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned FRAME_BITS = 1 + DATA_BITS + STOP_BITS;
  localparam int unsigned HALFBAUD   = half_baud(CLK_FREQ, BAUDRATE);
  localparam int unsigned CNT_MAX    = (FRAME_BITS > GAP_HALFBITS) ? FRAME_BITS : GAP_HALFBITS;
  localparam int unsigned BCW        = $clog2(CNT_MAX + 1);
  localparam logic [STOP_BITS-1:0] STOP_PAT = STOP_BITS'(STOP_LAST);

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  half_q, half_d;
  logic                  busy_q, busy_d;
  logic                  tx_q, tx_d;
  logic                  tmr_clear;
  logic                  tmr_wrap;

  manch_halfbit_timer #(
    .HALFBAUD(HALFBAUD)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear_i(tmr_clear),
    .wrap_o (tmr_wrap)
  );

  assign tx_ready = (state_q == IDLE_S);
  assign tx       = tx_q;
  assign busy     = busy_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    half_d    = half_q;
    busy_d    = busy_q;
    tx_d      = 1'b1;
    tmr_clear = 1'b0;
    case (state_q)
      GAP_S: begin
        // bit_cnt doubles as the guard-gap half-bit counter here
        if (tmr_wrap) begin
          if (bit_cnt_q == BCW'(GAP_HALFBITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = IDLE_S;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      IDLE_S: begin
        if (tx_valid) begin
          shreg_d   = {1'b0, tx_data, STOP_PAT};
          busy_d    = 1'b1;
          tmr_clear = 1'b1;
          bit_cnt_d = '0;
          half_d    = 1'b0;
          state_d   = SEND_S;
        end
      end
      SEND_S: begin
        tx_d = half_q ? shreg_q[FRAME_BITS-1] : ~shreg_q[FRAME_BITS-1];
        if (tmr_wrap) begin
          half_d = ~half_q;
          if (half_q) begin
            shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b1};
            if (bit_cnt_q == BCW'(FRAME_BITS - 1)) begin
              bit_cnt_d = '0;
              busy_d    = 1'b0;
              state_d   = GAP_S;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      default: begin
        // RESET_S and any corrupted encoding restart through the full gap
        tmr_clear = 1'b1;
        shreg_d   = '1;
        bit_cnt_d = '0;
        half_d    = 1'b0;
        busy_d    = 1'b0;
        state_d   = GAP_S;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RESET_S;
      shreg_q   <= '1;
      bit_cnt_q <= '0;
      half_q    <= 1'b0;
      busy_q    <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      half_q    <= half_d;
      busy_q    <= busy_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_manch_encoder.sv
// Self-checking bench for manch_encoder: timeline model compared every
// cycle, plus literal half-bit patterns and timing figures.
module tb_manch_encoder;

  localparam int HB          = 81;
  localparam int FRAME_CLKS  = 22 * HB;
  localparam int GAP_CLKS    = 4 * HB;
  localparam int RDY_AFTER_R = GAP_CLKS + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx, busy;

  always #5 clk = ~clk;

  manch_encoder dut (
    .clk     (clk),
    .reset   (reset),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data (tx_data),
    .tx      (tx),
    .busy    (busy)
  );

  int checks = 0;
  int errors = 0;

  // timeline model: edges since reset release, handshake edge, ready edge
  int         cyc = 0, hs = 0, ready_at = RDY_AFTER_R, hs_cnt = 0;
  bit         has_frame = 1'b0, was_ready;
  logic [7:0] m_data = 8'h00;

  // observations
  int         rise_cyc = -1, fall_cyc = -1, busy_cnt = 0, done_cnt = 0, done_busy = 0;
  bit         seen_ready = 1'b0, fall_seen = 1'b0;
  logic       prev_tx = 1'b1;
  logic [21:0] pat = '0, done_pat = '0;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // frame bit i: 0 start, 1..8 data MSB first, 9..10 stop bits 0 then 1
  function automatic logic frame_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[8 - i];
    return (i == 10);
  endfunction

  function automatic logic exp_tx(input int k);
    int j;
    if (!has_frame || k < 1 || k > FRAME_CLKS) return 1'b1;
    j = (k - 1) / HB;
    return (j % 2 == 0) ? !frame_bit(m_data, j / 2) : frame_bit(m_data, j / 2);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc        = 0;
      ready_at   = RDY_AFTER_R;
      has_frame  = 1'b0;
      seen_ready = 1'b0;
      rise_cyc   = -1;
    end else begin
      was_ready = (cyc >= ready_at);
      cyc++;
      if (was_ready && tx_valid) begin
        hs        = cyc;
        ready_at  = cyc + FRAME_CLKS + GAP_CLKS;
        has_frame = 1'b1;
        m_data    = tx_data;
        fall_seen = 1'b0;
        busy_cnt  = 0;
        hs_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    int k;
    if (reset) begin
      chk("rst_tx", tx, 1'b1);
      chk("rst_ready", tx_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      prev_tx = 1'b1;
    end else begin
      k = cyc - hs;
      chk("tx", tx, exp_tx(k));
      chk("busy", busy, has_frame && k >= 0 && k < FRAME_CLKS);
      chk("ready", tx_ready, cyc >= ready_at);
      if (tx_ready && !seen_ready) begin
        seen_ready = 1'b1;
        rise_cyc   = cyc;
      end
      if (has_frame && prev_tx && !tx && !fall_seen) begin
        fall_seen = 1'b1;
        fall_cyc  = cyc;
      end
      prev_tx = tx;
      if (has_frame && busy) busy_cnt++;
      if (has_frame && k >= 1 && k <= FRAME_CLKS && (k - 1) % HB == HB / 2)
        pat[21 - (k - 1) / HB] = tx;
      if (has_frame && k == FRAME_CLKS + 1) begin
        done_pat  = pat;
        done_busy = busy_cnt;
        done_cnt++;
      end
    end
  end

  task automatic wait_hs(input int prev);
    int n = 0;
    while (hs_cnt == prev && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (hs_cnt == prev) begin
      checks++;
      errors++;
      $display("FAIL hs_timeout: no handshake after %0d cycles", n);
    end
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_cnt == prev && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == prev) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: frame not completed after %0d cycles", n);
    end
  endtask

  task automatic send(input logic [7:0] d);
    int p = hs_cnt;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    wait_hs(p);
    tx_valid = 1'b0;
    tx_data  = ~d;
  endtask

  task automatic send_pattern(input string nm, input logic [7:0] d, input logic [21:0] exp_pat);
    int p;
    p = done_cnt;
    send(d);
    wait_done(p);
    lit(nm, int'(done_pat), int'(exp_pat));
    lit({nm, "_busy"}, done_busy, FRAME_CLKS);
  endtask

  initial begin
    int f1, f2, p, n;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (RDY_AFTER_R + 5) @(negedge clk);
    lit("ready_rise", rise_cyc, 325);

    send_pattern("pat_a5", 8'hA5, 22'b1001100110100110011001);
    lit("mid_latency", fall_cyc - hs, HB + 1);
    send_pattern("pat_00", 8'h00, 22'b1010101010101010101001);
    send_pattern("pat_ff", 8'hFF, 22'b1001010101010101011001);

    // tx_valid held high; data changes mid-frame must not leak in
    @(negedge clk);
    p = hs_cnt;
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    wait_hs(p);
    tx_data = 8'hC3;
    wait_done(done_cnt);
    lit("pat_3c", int'(done_pat), int'(22'b1010100101010110101001));
    f1 = fall_cyc;
    wait_hs(p + 1);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    wait_done(done_cnt);
    lit("pat_c3", int'(done_pat), int'(22'b1001011010101001011001));
    f2 = fall_cyc;
    // frame, guard gap, plus the one ready cycle the handshake needs
    lit("b2b_spacing", f2 - f1, FRAME_CLKS + GAP_CLKS + 1);

    // abort a frame while the line is low
    send(8'h3C);
    n = 0;
    while (cyc - hs < 500 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    lit("pre_reset_tx", int'(tx), 0);
    #1 reset = 1'b1;
    #1;
    lit("async_tx", int'(tx), 1);
    lit("async_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (RDY_AFTER_R + 5) @(negedge clk);
    lit("ready_rise_abort", rise_cyc, 325);

    for (int i = 0; i < 8; i++) begin
      p = done_cnt;
      send(8'($urandom_range(0, 255)));
      wait_done(p);
      lit("rnd_busy", done_busy, FRAME_CLKS);
    end
    repeat (400) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
